// File: rtl/sync_timekeeper.sv
// Local real-time clock: qualifies the quasi-static SPI time frame across domains,
// validates it, and keeps a free-running second..year counter in the clk domain.
module sync_timekeeper #(
    parameter int unsigned CLK_HZ = 25_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] frame,
    output logic        time_valid,
    output logic        sync_active,
    output logic        frame_err,
    output logic        tick_1hz,
    output logic [5:0]  second,
    output logic [5:0]  minute,
    output logic [4:0]  hour24,
    output logic [3:0]  hour12,
    output logic        pm,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [4:0]  year
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(CLK_HZ - 1);

    logic [31:0]   w1_q, w2_q, w3_q, last_q, last_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          valid_q, valid_d, err_q, err_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic [4:0]    hr_q, hr_d, day_q, day_d, yr_q, yr_d;
    logic [3:0]    mon_q, mon_d;

    logic       qual, accept, f_ok, load;
    logic [5:0] f_sec, f_min;
    logic [4:0] f_hr, f_day, f_yr;
    logic [3:0] f_mon;

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic [1:0] y_lo);
        case (m)
            4'd2:                      return (y_lo == 2'd0) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    assign f_yr  = w3_q[30:26];
    assign f_mon = w3_q[25:22];
    assign f_day = w3_q[21:17];
    assign f_hr  = w3_q[16:12];
    assign f_min = w3_q[11:6];
    assign f_sec = w3_q[5:0];

    // A word counts once it has been stable for two synchronizer stages and is new.
    always_comb begin
        qual   = (w2_q == w3_q) && (w3_q != last_q);
        accept = qual && !w3_q[31];
        f_ok   = (f_sec <= 6'd59) && (f_min <= 6'd59) && (f_hr <= 5'd23) &&
                 (f_mon >= 4'd1) && (f_mon <= 4'd12) &&
                 (f_day >= 5'd1) && (f_day <= month_len(f_mon, f_yr[1:0]));
        load   = accept && f_ok;
    end

    // A load in the terminal prescaler cycle swallows that second.
    assign tick_1hz = (presc_q == P_MAX) && !load;

    always_comb begin
        last_d  = accept ? w3_q : last_q;
        err_d   = accept && !f_ok;
        valid_d = valid_q | load;
        presc_d = (load || presc_q == P_MAX) ? '0 : presc_q + PW'(1);
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        day_d   = day_q;
        mon_d   = mon_q;
        yr_d    = yr_q;
        if (load) begin
            sec_d = f_sec;
            min_d = f_min;
            hr_d  = f_hr;
            day_d = f_day;
            mon_d = f_mon;
            yr_d  = f_yr;
        end else if (tick_1hz) begin
            if (sec_q != 6'd59) begin
                sec_d = sec_q + 6'd1;
            end else begin
                sec_d = 6'd0;
                if (min_q != 6'd59) begin
                    min_d = min_q + 6'd1;
                end else begin
                    min_d = 6'd0;
                    if (hr_q != 5'd23) begin
                        hr_d = hr_q + 5'd1;
                    end else begin
                        hr_d = 5'd0;
                        if (day_q != month_len(mon_q, yr_q[1:0])) begin
                            day_d = day_q + 5'd1;
                        end else begin
                            day_d = 5'd1;
                            if (mon_q != 4'd12) begin
                                mon_d = mon_q + 4'd1;
                            end else begin
                                mon_d = 4'd1;
                                yr_d  = (yr_q == 5'd31) ? 5'd0 : yr_q + 5'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            last_q  <= '0;
            presc_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hr_q    <= 5'd0;
            day_q   <= 5'd1;
            mon_q   <= 4'd1;
            yr_q    <= 5'd0;
        end else begin
            w1_q    <= frame;
            w2_q    <= w1_q;
            w3_q    <= w2_q;
            last_q  <= last_d;
            presc_q <= presc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            day_q   <= day_d;
            mon_q   <= mon_d;
            yr_q    <= yr_d;
        end
    end

    assign time_valid  = valid_q;
    assign sync_active = w3_q[31];
    assign frame_err   = err_q;
    assign second      = sec_q;
    assign minute      = min_q;
    assign hour24      = hr_q;
    assign pm          = (hr_q >= 5'd12);
    assign hour12      = 4'(pm ? hr_q - 5'd12 : hr_q);
    assign day         = day_q;
    assign month       = mon_q;
    assign year        = yr_q;

endmodule
